// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO result bus between the control unit and the mul/div sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_by_zero;

    modport master (
        output start, op, opA, opB,
        input  busy, done, hi_we, lo_we, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start, op, opA, opB,
        output busy, done, hi_we, lo_we, hi_out, lo_out, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// producing one HI/LO result per accepted start.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, MUL_ITER, DIV_ITER, FIXUP, DONE} state_t;

    state_t           state;
    logic             op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q, mcand, rem, divisor;
    logic             q_m1, s_a, s_b;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH:0]   mc_ext, booth_sum, trial;
    logic [WIDTH-1:0] rem_sh, abs_a, abs_b;

    // Accumulator is one bit wider so the most-negative multiplicand cannot overflow.
    always_comb begin
        mc_ext    = {mcand[WIDTH-1], mcand};
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + mc_ext;
            2'b10:   booth_sum = acc - mc_ext;
            default: booth_sum = acc;
        endcase
        rem_sh = {rem[WIDTH-2:0], q[WIDTH-1]};
        trial  = {1'b0, rem_sh} - {1'b0, divisor};
        abs_a  = a_q[WIDTH-1] ? -a_q : a_q;
        abs_b  = b_q[WIDTH-1] ? -b_q : b_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            mcand   <= '0;
            rem     <= '0;
            divisor <= '0;
            s_a     <= 1'b0;
            s_b     <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    op_q   <= bus.op;
                    a_q    <= bus.opA;
                    b_q    <= bus.opB;
                    busy_q <= 1'b1;
                    dbz_q  <= 1'b0;
                    state  <= LOAD;
                end
                LOAD: begin
                    cnt  <= CW'(WIDTH);
                    q_m1 <= 1'b0;
                    if (!op_q) begin
                        acc   <= '0;
                        q     <= a_q;
                        mcand <= b_q;
                        state <= MUL_ITER;
                    end else if (b_q != '0) begin
                        rem     <= '0;
                        q       <= abs_a;
                        divisor <= abs_b;
                        s_a     <= a_q[WIDTH-1];
                        s_b     <= b_q[WIDTH-1];
                        state   <= DIV_ITER;
                    end else begin
                        // Divide by zero skips straight to DONE with a fixed result.
                        hi_q   <= a_q;
                        lo_q   <= '1;
                        dbz_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                MUL_ITER: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIXUP;
                end
                DIV_ITER: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    if (!op_q) begin
                        hi_q <= acc[WIDTH-1:0];
                        lo_q <= q;
                    end else begin
                        lo_q <= (s_a ^ s_b) ? -q : q;
                        hi_q <= s_a ? -rem : rem;
                    end
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi_we       = done_q;
    assign bus.lo_we       = done_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results, a monitor pops them on done.
module tb_muldiv_sequencer;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic done_prev = 1'b0;
    exp_t sb[$];

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset) begin
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                check("done_one_cycle", {31'b0, bus.done}, 0);
                check("we_one_cycle", {30'b0, bus.hi_we, bus.lo_we}, 0);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("hi_out", bus.hi_out, e.hi);
                    check("lo_out", bus.lo_out, e.lo);
                    check("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
                    check("done_cycle", cyc, e.due);
                    check("hi_lo_we", {30'b0, bus.hi_we, bus.lo_we}, 32'd3);
                    check("busy_in_done", {31'b0, bus.busy}, 1);
                end
            end
            done_prev = bus.done;
        end
    end

    // Called just after a negedge; leaves the bench at the negedge of cycle 1.
    task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz,
                         input int lat);
        exp_t e;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        bus.start = 1'b1;
        e.hi  = hi;
        e.lo  = lo;
        e.dbz = dbz;
        e.due = cyc + lat;
        sb.push_back(e);
        @(negedge Clock);
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.opA   = 32'hDEADBEEF;
        bus.opB   = 32'h0BADF00D;
    endtask

    // Counts busy cycles until done, then steps to the IDLE cycle after DONE.
    task automatic wait_done(output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 80 && !seen; k++) begin
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1'b1;
            else @(negedge Clock);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got no done within 80 cycles, want done (cycle %0d)", cyc);
        end
        @(negedge Clock);
    endtask

    initial begin
        int nb;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.opA   = '0;
        bus.opB   = '0;
        repeat (2) @(negedge Clock);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_done_we", {29'b0, bus.done, bus.hi_we, bus.lo_we}, 0);
        check("rst_dbz", {31'b0, bus.div_by_zero}, 0);
        check("rst_hi", bus.hi_out, 0);
        check("rst_lo", bus.lo_out, 0);
        Reset = 1'b1;
        @(negedge Clock);

        issue(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35);
        wait_done(nb);

        issue(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 35);
        check("busy_cycle1", {31'b0, bus.busy}, 1);
        wait_done(nb);
        check("busy_cycles", nb, 35);
        check("busy_after_done", {31'b0, bus.busy}, 0);

        issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35);
        wait_done(nb);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 35);
        wait_done(nb);
        issue(1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 35);
        wait_done(nb);

        issue(1'b1, 32'd100, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b1, 2);
        wait_done(nb);
        check("dbz_busy_cycles", nb, 2);
        check("dbz_held", {31'b0, bus.div_by_zero}, 1);

        // Second start mid-operation must be ignored.
        issue(1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 35);
        check("dbz_cleared", {31'b0, bus.div_by_zero}, 0);
        repeat (9) @(negedge Clock);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.opA   = 32'd9;
        bus.opB   = 32'd3;
        @(negedge Clock);
        bus.start = 1'b0;
        wait_done(nb);

        // Back-to-back: issued in the IDLE cycle right after DONE.
        issue(1'b0, 32'hFFFFFFFC, 32'h12345678, 32'hFFFFFFFF, 32'hB72EA620, 1'b0, 35);
        check("b2b_busy", {31'b0, bus.busy}, 1);
        wait_done(nb);

        // Reset mid-divide aborts with no done.
        issue(1'b1, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 35);
        repeat (11) @(negedge Clock);
        Reset = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_busy", {31'b0, bus.busy}, 0);
        check("abort_done", {31'b0, bus.done}, 0);
        check("abort_hi", bus.hi_out, 0);
        check("abort_lo", bus.lo_out, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("post_abort_idle", {31'b0, bus.busy}, 0);
        issue(1'b1, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 35);
        wait_done(nb);

        repeat (3) @(negedge Clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for signed 32-bit multiply and divide, driving the HI/LO register pair.
- Replaces the single-cycle mul/div path. The control unit issues a start pulse with operands, holds its mul/div state while busy is high, and resumes on done.
- Multiply uses radix-2 Booth; divide uses restoring division on magnitudes with sign fix-up.
- One result per operation: HI/LO write strobes pulse together with done.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH split across HI/LO; iteration count equals WIDTH.

Ports:
Clock  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = multiply, 1 = divide; captured with start.
opA  input  WIDTH  multiplicand / dividend (signed); captured with start.
opB  input  WIDTH  multiplier / divisor (signed); captured with start.
busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
done  output  1  one-cycle pulse in the DONE state.
hi_we  output  1  equals done; HI register write strobe.
lo_we  output  1  equals done; LO register write strobe.
hi_out  output  WIDTH  mul: product[2W-1:W]; div: remainder. Registered; holds until the next done.
lo_out  output  WIDTH  mul: product[W-1:0]; div: quotient. Registered; holds until the next done.
div_by_zero  output  1  registered; set at done of a divide with opB = 0, cleared at the next accepted start.

Behaviour:
- Reset (Reset = 0, asynchronous): state goes to IDLE; busy, done, hi_we, lo_we, div_by_zero = 0; hi_out, lo_out and all internal registers = 0.
- States: IDLE, LOAD, MUL_ITER, DIV_ITER, FIXUP, DONE.
- IDLE: start = 1 at an edge captures op, opA and opB, and moves to LOAD. start = 0 stays in IDLE.
- LOAD (1 cycle):
  - mul: accumulator = 0, Q = opA, Q(-1) = 0, multiplicand = opB, counter = WIDTH.
  - div: remainder = 0, Q = |opA|, divisor = |opB|; record sign flags sA = opA[MSB], sB = opB[MSB]; counter = WIDTH.
  - |x| of the most-negative value is 2^(W-1), held in an unsigned W-bit register.
  - Next state: op = 0 -> MUL_ITER; op = 1 with opB != 0 -> DIV_ITER; op = 1 with opB = 0 -> DONE.
- MUL_ITER (WIDTH cycles), one Booth step per cycle:
  - {Q0, Q(-1)} = 01 adds multiplicand to the accumulator; 10 subtracts it; 00/11 does nothing.
  - Then arithmetic-shift {acc, Q, Q(-1)} right by one.
  - Accumulator is W+1 bits wide to avoid overflow on the most-negative operand.
  - Decrement the counter; at 0 go to FIXUP.
- DIV_ITER (WIDTH cycles):
  - Shift {rem, Q} left by one.
  - trial = rem - divisor, computed W+1 bits wide. If trial >= 0, rem = trial and Q0 = 1; else Q0 = 0.
  - Decrement the counter; at 0 go to FIXUP.
- FIXUP (1 cycle):
  - mul: hi_out = acc[W-1:0], lo_out = Q.
  - div: lo_out = (sA ^ sB) ? -Q : Q; hi_out = sA ? -rem : rem.
  - Go to DONE.
- DONE (1 cycle): done = hi_we = lo_we = 1, then go to IDLE.
  - Divide-by-zero path: hi_out = opA, lo_out = all-ones, div_by_zero = 1, all written on the LOAD -> DONE edge.
- Latency, counting start accepted at edge 0:
  - Normal operation: LOAD in cycle 1, iterations in cycles 2..W+1, FIXUP in cycle W+2, DONE (done = 1) in cycle W+3, which is cycle 35 for W = 32.
  - Divide by zero: DONE in cycle 2.
  - Back-to-back: a new start is accepted in the IDLE cycle right after DONE.
- Boundary conditions:
  - start while busy is ignored; no queueing; operands are not re-captured.
  - opA/opB changing after capture has no effect on the result.
  - Most-negative / -1 gives lo_out = 0x80000000, hi_out = 0 (wraps, no flag).
  - Reset asserted mid-operation aborts immediately: no done or strobes, hi_out/lo_out return to 0.
  - done is never high for more than one cycle. busy and done are high together in DONE.

Test Plan:
- mul 7 x -3 (opA = 7, opB = 0xFFFFFFFD) -> done in cycle 35; hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB; hi_we = lo_we = 1 for exactly one cycle.
- mul 0x80000000 x 0x80000000 -> hi_out = 0x40000000, lo_out = 0x00000000; busy high cycles 1..35.
- div -7 / 2 -> lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF, div_by_zero = 0. Then div 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0.
- div 100 / 0 -> done in cycle 2; lo_out = 0xFFFFFFFF, hi_out = 0x00000064, div_by_zero = 1. A following mul start clears div_by_zero on acceptance.
- Start mul 5 x 6, pulse start again with different operands in cycle 10 -> second start ignored; result hi = 0, lo = 30 at cycle 35. Next start is accepted in cycle 36 (IDLE).
- Start div 1000 / 7, drive Reset low in cycle 12 -> busy, done and outputs go to 0 asynchronously with no done pulse. After release, div 1000 / 7 completes with lo = 142, hi = 6.
